// File: rtl/fifo_stream_reader_pkg.sv
// Shared types for the FIFO-to-stream packet reader.
// Holds the reader state encoding and the packet counter width.
package fifo_stream_reader_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    STREAM   = 2'd1,
    STOPPING = 2'd2
  } state_t;

  localparam int PKT_CNT_W = 16;

endpackage

// File: rtl/fifo_stream_reader_skid.sv
// stream_skid_buf: 2-entry in-order output buffer, write-to-valid latency 1 cycle.
// Backpressure: holds the oldest entry stable while rd_rdy is low; the writer must not push when full without a read.
module stream_skid_buf #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         wr_vld,
  input  logic [W-1:0] wr_dat,
  input  logic         rd_rdy,
  output logic         rd_vld,
  output logic [W-1:0] rd_dat,
  output logic [1:0]   cnt
);

  logic [W-1:0] ent0, ent1;
  logic         rd;

  assign rd_vld = (cnt != 2'd0);
  assign rd_dat = ent0;
  assign rd     = rd_vld && rd_rdy;

  // ent0 is always the oldest word; ent1 only holds data when cnt==2
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ent0 <= '0;
      ent1 <= '0;
      cnt  <= 2'd0;
    end else begin
      case ({wr_vld, rd})
        2'b10: begin
          if (cnt == 2'd0) ent0 <= wr_dat;
          else             ent1 <= wr_dat;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          ent0 <= ent1;
          cnt  <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd2) begin
            ent0 <= ent1;
            ent1 <= wr_dat;
          end else begin
            ent0 <= wr_dat;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_stream_reader.sv
// Pops fixed-length packets from a registered-read FIFO onto a valid/ready stream; pop-to-valid latency 1 cycle.
// Backpressure: pops stop once the 2-entry output buffer is full and no word leaves in the same cycle.
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int ABITS   = 4,
  parameter int PKT_LEN = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 enable,
  output logic                 fifo_enable,
  input  logic [WIDTH-1:0]     fifo_data,
  input  logic [ABITS-1:0]     fifo_avail,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [WIDTH-1:0]     m_data,
  output logic                 m_last,
  output logic                 busy,
  output logic [PKT_CNT_W-1:0] pkt_cnt
);

  localparam logic [15:0] LAST_BEAT = 16'(PKT_LEN - 1);

  state_t           state, state_nxt;
  logic [15:0]      beat_idx, beat_nxt;
  logic             pop_q;
  logic [ABITS-1:0] eff_avail;
  logic [1:0]       buf_cnt;
  logic [WIDTH:0]   buf_dat;
  logic             xfer;
  logic             pop_last;

  // fifo_avail still counts the word popped on the previous edge
  assign eff_avail = fifo_avail - {{(ABITS-1){1'b0}}, pop_q};
  assign xfer      = m_valid && m_ready;
  assign pop_last  = (beat_idx == LAST_BEAT);

  always_comb begin
    fifo_enable = 1'b0;
    beat_nxt    = beat_idx;
    state_nxt   = state;

    fifo_enable = (state != IDLE) && (eff_avail != '0) &&
                  ((buf_cnt != 2'd2) || xfer);
    if (fifo_enable) beat_nxt = pop_last ? 16'd0 : beat_idx + 16'd1;

    // leaving STREAM looks at the post-pop beat so a pop this cycle never strands a packet
    case (state)
      IDLE:     if (enable) state_nxt = STREAM;
      STREAM:   if (!enable) state_nxt = (beat_nxt == 16'd0) ? IDLE : STOPPING;
      STOPPING: begin
        if (enable)                       state_nxt = STREAM;
        else if (fifo_enable && pop_last) state_nxt = IDLE;
      end
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      beat_idx <= 16'd0;
      pop_q    <= 1'b0;
      pkt_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      beat_idx <= beat_nxt;
      pop_q    <= fifo_enable;
      if (xfer && m_last) pkt_cnt <= pkt_cnt + 1'b1;
    end
  end

  stream_skid_buf #(
    .W (WIDTH + 1)
  ) u_skid (
    .clk    (clk),
    .resetn (resetn),
    .wr_vld (fifo_enable),
    .wr_dat ({pop_last, fifo_data}),
    .rd_rdy (m_ready),
    .rd_vld (m_valid),
    .rd_dat (buf_dat),
    .cnt    (buf_cnt)
  );

  assign m_last = buf_dat[WIDTH];
  assign m_data = buf_dat[WIDTH-1:0];
  assign busy   = (state != IDLE) || (buf_cnt != 2'd0);

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader with a registered-read FIFO model and an expected-word queue.
module tb_fifo_stream_reader;

  localparam int WIDTH   = 8;
  localparam int ABITS   = 4;
  localparam int PKT_LEN = 4;

  logic             clk = 1'b0;
  logic             resetn;
  logic             enable;
  logic             fifo_enable;
  logic [WIDTH-1:0] fifo_data;
  logic [ABITS-1:0] fifo_avail;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic             m_last;
  logic             busy;
  logic [15:0]      pkt_cnt;

  always #5 clk = ~clk;

  fifo_stream_reader #(
    .WIDTH   (WIDTH),
    .ABITS   (ABITS),
    .PKT_LEN (PKT_LEN)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .enable      (enable),
    .fifo_enable (fifo_enable),
    .fifo_data   (fifo_data),
    .fifo_avail  (fifo_avail),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_last      (m_last),
    .busy        (busy),
    .pkt_cnt     (pkt_cnt)
  );

  typedef struct {
    int n_words;
    int rdy_mode;
    int exp_pkt;
    int exp_span;
  } vec_t;

  vec_t       vecs[5];
  logic [7:0] q[$];
  logic [8:0] exp_q[$];
  int errors = 0, checks = 0;
  int cyc = 0, pops = 0, pops0 = 0, last_pop_cyc = 0, rel_cyc = 0;
  int first_xfer_cyc = -1, last_xfer_cyc = -1;
  int rdy_mode = 0, push_idx = 0, n = 0;
  logic [7:0] next_val = 8'h10;
  logic       prev_hold = 1'b0;
  logic [8:0] prev_word = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // One clock: monitor at negedge, FIFO model and ready pattern update 1ns after the rising edge
  task automatic tick();
    logic pop_now;
    @(negedge clk);
    pop_now = fifo_enable;
    if (resetn && m_valid) begin
      if (prev_hold) chk("hold_stable", {23'd0, m_last, m_data}, {23'd0, prev_word});
      if (m_ready) begin
        if (exp_q.size() == 0) chk("unexpected_word", 0, 1);
        else chk("word", {23'd0, m_last, m_data}, {23'd0, exp_q.pop_front()});
        if (first_xfer_cyc < 0) first_xfer_cyc = cyc;
        last_xfer_cyc = cyc;
      end
      prev_hold = !m_ready;
      prev_word = {m_last, m_data};
    end else begin
      prev_hold = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
    fifo_avail = 4'(q.size());
    if (pop_now) begin
      if (q.size() > 0) void'(q.pop_front());
      else chk("pop_on_empty", 0, 1);
      pops++;
      last_pop_cyc = cyc;
    end
    fifo_data = (q.size() > 0) ? q[0] : 8'h00;
    if (rdy_mode == 1)      m_ready = (cyc % 2 == 0);
    else if (rdy_mode == 2) m_ready = (cyc % 3 == 0);
  endtask

  task automatic push_words(input int cnt);
    logic lst;
    for (int i = 0; i < cnt; i++) begin
      lst = ((push_idx % PKT_LEN) == PKT_LEN - 1);
      q.push_back(next_val);
      exp_q.push_back({lst, next_val});
      next_val++;
      push_idx++;
    end
  endtask

  task automatic do_reset();
    resetn    = 1'b0;
    enable    = 1'b0;
    m_ready   = 1'b1;
    rdy_mode  = 0;
    q.delete();
    exp_q.delete();
    push_idx  = 0;
    next_val  = 8'h10;
    prev_hold = 1'b0;
    tick();
    tick();
  endtask

  task automatic release_rst();
    resetn  = 1'b1;
    rel_cyc = cyc;
  endtask

  task automatic run_until_pops(input int target, input int budget, input string name);
    int k = 0;
    while (pops < target && k < budget) begin
      tick();
      k++;
    end
    chk(name, {31'd0, pops >= target}, 1);
  endtask

  task automatic wait_drain(input int budget, input string name);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    vecs[0] = '{n_words: 8,  rdy_mode: 0, exp_pkt: 2, exp_span: 7};
    vecs[1] = '{n_words: 4,  rdy_mode: 1, exp_pkt: 1, exp_span: -1};
    vecs[2] = '{n_words: 12, rdy_mode: 2, exp_pkt: 3, exp_span: -1};
    vecs[3] = '{n_words: 0,  rdy_mode: 0, exp_pkt: 0, exp_span: -1};
    vecs[4] = '{n_words: 12, rdy_mode: 0, exp_pkt: 3, exp_span: 11};

    resetn = 1'b0; enable = 1'b0; m_ready = 1'b1;
    fifo_data = '0; fifo_avail = '0;
    do_reset();
    chk("rst_fifo_enable", {31'd0, fifo_enable}, 0);
    chk("rst_m_valid", {31'd0, m_valid}, 0);
    chk("rst_m_last", {31'd0, m_last}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_m_data", {24'd0, m_data}, 0);
    chk("rst_pkt_cnt", {16'd0, pkt_cnt}, 0);
    release_rst();

    // Table: preload, stream under a ready pattern, then stop
    for (int i = 0; i < 5; i++) begin
      do_reset();
      release_rst();
      push_words(vecs[i].n_words);
      pops0 = pops;
      first_xfer_cyc = -1;
      rdy_mode = vecs[i].rdy_mode;
      enable = 1'b1;
      for (int k = 0; k < 3; k++) tick();
      n = 0;
      while ((pops - pops0 < vecs[i].n_words || exp_q.size() != 0) && n < 300) begin
        tick();
        n++;
      end
      enable = 1'b0;
      rdy_mode = 0;
      m_ready = 1'b1;
      for (int k = 0; k < 4; k++) tick();
      chk($sformatf("vec%0d_pkt_cnt", i), {16'd0, pkt_cnt}, vecs[i].exp_pkt);
      chk($sformatf("vec%0d_pops", i), pops - pops0, vecs[i].n_words);
      chk($sformatf("vec%0d_busy", i), {31'd0, busy}, 0);
      chk($sformatf("vec%0d_left", i), exp_q.size(), 0);
      if (vecs[i].exp_span >= 0)
        chk($sformatf("vec%0d_span", i), last_xfer_cyc - first_xfer_cyc, vecs[i].exp_span);
    end

    // Stale occupancy: one word, over-reported the cycle after its pop
    do_reset();
    release_rst();
    push_words(1);
    pops0 = pops;
    m_ready = 1'b0;
    enable = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    chk("stale_pops", pops - pops0, 1);
    chk("stale_valid", {31'd0, m_valid}, 1);
    chk("stale_data", {24'd0, m_data}, 32'h10);
    m_ready = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    chk("stale_drained", exp_q.size(), 0);
    enable = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    chk("stale_stopping_busy", {31'd0, busy}, 1);

    // Backpressure with a deep FIFO
    do_reset();
    release_rst();
    push_words(12);
    pops0 = pops;
    m_ready = 1'b0;
    enable = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    chk("bp_pops_le2", {31'd0, (pops - pops0) <= 2}, 1);
    chk("bp_valid", {31'd0, m_valid}, 1);
    chk("bp_head", {24'd0, m_data}, 32'h10);
    m_ready = 1'b1;
    wait_drain(60, "bp_drain");
    chk("bp_pkt_cnt", {16'd0, pkt_cnt}, 3);
    enable = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    chk("bp_busy", {31'd0, busy}, 0);

    // Stop after 2 of 4 words: packet completes, nothing further popped
    do_reset();
    release_rst();
    push_words(8);
    pops0 = pops;
    enable = 1'b1;
    run_until_pops(pops0 + 2, 20, "stop_wait");
    enable = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    chk("stop_pops", pops - pops0, 4);
    chk("stop_pkt_cnt", {16'd0, pkt_cnt}, 1);
    chk("stop_busy", {31'd0, busy}, 0);
    chk("stop_left", exp_q.size(), 4);

    // Re-enable while stopping: popping continues without a gap
    do_reset();
    release_rst();
    push_words(8);
    pops0 = pops;
    first_xfer_cyc = -1;
    enable = 1'b1;
    run_until_pops(pops0 + 2, 20, "reen_wait");
    enable = 1'b0;
    tick();
    enable = 1'b1;
    wait_drain(30, "reen_drain");
    chk("reen_span", last_xfer_cyc - first_xfer_cyc, 7);
    chk("reen_pkt_cnt", {16'd0, pkt_cnt}, 2);

    // Underflow stall mid-packet
    do_reset();
    release_rst();
    push_words(1);
    pops0 = pops;
    enable = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    chk("uf_pops", pops - pops0, 1);
    for (int k = 0; k < 5; k++) tick();
    chk("uf_gap_valid", {31'd0, m_valid}, 0);
    push_words(3);
    wait_drain(30, "uf_drain");
    chk("uf_pkt_cnt", {16'd0, pkt_cnt}, 1);
    chk("uf_total_pops", pops - pops0, 4);
    enable = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    chk("uf_busy", {31'd0, busy}, 0);

    // Async reset with a full output buffer mid-packet
    do_reset();
    release_rst();
    push_words(12);
    pops0 = pops;
    enable = 1'b1;
    run_until_pops(pops0 + 6, 30, "ar_wait");
    m_ready = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("ar_pre_valid", {31'd0, m_valid}, 1);
    chk("ar_pre_pkt_cnt", {16'd0, pkt_cnt}, 1);
    #2;
    resetn = 1'b0;
    #1;
    chk("ar_valid", {31'd0, m_valid}, 0);
    chk("ar_pkt_cnt", {16'd0, pkt_cnt}, 0);
    chk("ar_busy", {31'd0, busy}, 0);
    chk("ar_fifo_enable", {31'd0, fifo_enable}, 0);
    chk("ar_m_data", {24'd0, m_data}, 0);
    q.delete();
    exp_q.delete();
    push_idx = 0;
    next_val = 8'h40;
    prev_hold = 1'b0;
    m_ready = 1'b1;
    push_words(4);
    tick();
    tick();
    release_rst();
    pops0 = pops;
    run_until_pops(pops0 + 1, 10, "ar_first_pop");
    chk("ar_first_pop_delay", {31'd0, (last_pop_cyc - rel_cyc) >= 2}, 1);
    wait_drain(30, "ar_drain");
    chk("ar_post_pkt_cnt", {16'd0, pkt_cnt}, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
